// File: rtl/axi_nm_interconnect.sv
// N-master to 1-slave AXI4 interconnect. The read and write paths each have
// their own arbiter and FSM, and each allows one outstanding transaction.
// The granted index is prefixed onto the slave-side ID. Responses are routed
// by the registered grant, so the returned prefix is only stripped.

// Winner selection. In round-robin mode the scan starts at ptr and wraps.
// Fixed priority is the same scan started at 0.
module axi_nm_arb #(
    parameter int N_MST    = 2,
    parameter int MIDX_W   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic [N_MST-1:0]  req,
    input  logic [MIDX_W-1:0] ptr,
    output logic [MIDX_W-1:0] win
);
    logic found;

    // First pass covers indices at or above the pointer; the second pass wraps.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int j = 0; j < N_MST; j++) begin
            if (!found && req[j] && (ARB_MODE == 1 || j >= int'(ptr))) begin
                win   = MIDX_W'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < N_MST; j++) begin
            if (!found && req[j]) begin
                win   = MIDX_W'(j);
                found = 1'b1;
            end
        end
    end
endmodule

module axi_nm_interconnect #(
    parameter int N_MST    = 2,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 4,
    parameter int ARB_MODE = 0,
    localparam int MIDX_W  = (N_MST > 1) ? $clog2(N_MST) : 1,
    localparam int STRB_W  = DATA_W / 8,
    localparam int SID_W   = ID_W + MIDX_W,
    localparam int AP_W    = ID_W + ADDR_W + 13,
    localparam int WP_W    = DATA_W + STRB_W + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MST-1:0]              m_awvalid,
    output logic [N_MST-1:0]              m_awready,
    input  logic [N_MST*AP_W-1:0]         m_awpay,
    input  logic [N_MST-1:0]              m_wvalid,
    output logic [N_MST-1:0]              m_wready,
    input  logic [N_MST*WP_W-1:0]         m_wpay,
    output logic [N_MST-1:0]              m_bvalid,
    input  logic [N_MST-1:0]              m_bready,
    output logic [ID_W+1:0]               m_bpay,
    input  logic [N_MST-1:0]              m_arvalid,
    output logic [N_MST-1:0]              m_arready,
    input  logic [N_MST*AP_W-1:0]         m_arpay,
    output logic [N_MST-1:0]              m_rvalid,
    input  logic [N_MST-1:0]              m_rready,
    output logic [ID_W+DATA_W+2:0]        m_rpay,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [SID_W+ADDR_W+12:0]      s_awpay,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    output logic [WP_W-1:0]               s_wpay,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    input  logic [SID_W+1:0]              s_bpay,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    output logic [SID_W+ADDR_W+12:0]      s_arpay,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [SID_W+DATA_W+2:0]       s_rpay
);
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    rstate_t rstate, rstate_nxt;
    wstate_t wstate, wstate_nxt;
    logic [MIDX_W-1:0] rgrant, rgrant_nxt, rptr, rptr_nxt, rwin;
    logic [MIDX_W-1:0] wgrant, wgrant_nxt, wptr, wptr_nxt, wwin;

    // The returned ID prefix is informational only.
    logic unused_prefix;
    assign unused_prefix = ^{s_rpay[SID_W+DATA_W+2 -: MIDX_W], s_bpay[SID_W+1 -: MIDX_W]};

    function automatic logic [MIDX_W-1:0] next_idx(input logic [MIDX_W-1:0] g);
        return (int'(g) == N_MST - 1) ? '0 : g + 1'b1;
    endfunction

    axi_nm_arb #(.N_MST(N_MST), .MIDX_W(MIDX_W), .ARB_MODE(ARB_MODE)) u_rarb (
        .req(m_arvalid), .ptr(rptr), .win(rwin));
    axi_nm_arb #(.N_MST(N_MST), .MIDX_W(MIDX_W), .ARB_MODE(ARB_MODE)) u_warb (
        .req(m_awvalid), .ptr(wptr), .win(wwin));

    // State, grant and pointer registers for both paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            rgrant <= '0;
            rptr   <= '0;
            wstate <= W_IDLE;
            wgrant <= '0;
            wptr   <= '0;
        end else begin
            rstate <= rstate_nxt;
            rgrant <= rgrant_nxt;
            rptr   <= rptr_nxt;
            wstate <= wstate_nxt;
            wgrant <= wgrant_nxt;
            wptr   <= wptr_nxt;
        end
    end

    // Read path: arbitrate in one cycle, then route AR and R through the grant.
    always_comb begin
        rstate_nxt = rstate;
        rgrant_nxt = rgrant;
        rptr_nxt   = rptr;
        s_arvalid  = 1'b0;
        m_arready  = '0;
        s_rready   = 1'b0;
        m_rvalid   = '0;
        s_arpay    = {rgrant, m_arpay[rgrant*AP_W +: AP_W]};
        m_rpay     = s_rpay[ID_W+DATA_W+2:0];
        case (rstate)
            R_IDLE: if (|m_arvalid) begin
                rgrant_nxt = rwin;
                rstate_nxt = R_ADDR;
            end
            R_ADDR: begin
                s_arvalid         = m_arvalid[rgrant];
                m_arready[rgrant] = s_arready;
                if (s_arvalid && s_arready) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                m_rvalid[rgrant] = s_rvalid;
                s_rready         = m_rready[rgrant];
                if (s_rvalid && s_rready && s_rpay[0]) begin
                    rstate_nxt = R_IDLE;
                    rptr_nxt   = next_idx(rgrant);
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Write path: W is held off until AW is accepted, and B is routed back to the grant.
    always_comb begin
        wstate_nxt = wstate;
        wgrant_nxt = wgrant;
        wptr_nxt   = wptr;
        s_awvalid  = 1'b0;
        m_awready  = '0;
        s_wvalid   = 1'b0;
        m_wready   = '0;
        s_bready   = 1'b0;
        m_bvalid   = '0;
        s_awpay    = {wgrant, m_awpay[wgrant*AP_W +: AP_W]};
        s_wpay     = m_wpay[wgrant*WP_W +: WP_W];
        m_bpay     = s_bpay[ID_W+1:0];
        case (wstate)
            W_IDLE: if (|m_awvalid) begin
                wgrant_nxt = wwin;
                wstate_nxt = W_ADDR;
            end
            W_ADDR: begin
                s_awvalid         = m_awvalid[wgrant];
                m_awready[wgrant] = s_awready;
                if (s_awvalid && s_awready) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_wvalid         = m_wvalid[wgrant];
                m_wready[wgrant] = s_wready;
                if (s_wvalid && s_wready && s_wpay[0]) wstate_nxt = W_RESP;
            end
            W_RESP: begin
                m_bvalid[wgrant] = s_bvalid;
                s_bready         = m_bready[wgrant];
                if (s_bvalid && s_bready) begin
                    wstate_nxt = W_IDLE;
                    wptr_nxt   = next_idx(wgrant);
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_nm_interconnect.sv
// Bench for axi_nm_interconnect. One round-robin instance and one
// fixed-priority instance share all input stimulus. Inputs are driven on
// the falling edge and outputs are sampled 1 ns later.
module tb_axi_nm_interconnect;
    localparam int N = 2, AW = 32, DW = 32, IW = 4, SW = DW / 8, MW = 1;
    localparam int AP = IW + AW + 13, WP = DW + SW + 1, BP = IW + 2, RP = IW + DW + 3;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [N*AP-1:0] m_awpay, m_arpay;
    logic [N*WP-1:0] m_wpay;
    logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [MW+BP-1:0] s_bpay;
    logic [MW+RP-1:0] s_rpay;

    logic [N-1:0] m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [BP-1:0] m_bpay;
    logic [RP-1:0] m_rpay;
    logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [MW+AP-1:0] s_awpay, s_arpay;
    logic [WP-1:0] s_wpay;

    logic [N-1:0] f_awready, f_wready, f_bvalid, f_arready, f_rvalid;
    logic [BP-1:0] f_bpay;
    logic [RP-1:0] f_rpay;
    logic f_awvalid, f_wvalid, f_bready, f_arvalid, f_rready;
    logic [MW+AP-1:0] f_awpay, f_arpay;
    logic [WP-1:0] f_wpay;

    logic [14:0] vr, f_vr;
    assign vr   = {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                   s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
    assign f_vr = {f_awready, f_wready, f_bvalid, f_arready, f_rvalid,
                   f_awvalid, f_wvalid, f_bready, f_arvalid, f_rready};

    axi_nm_interconnect #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awpay(m_awpay),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wpay(m_wpay),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bpay(m_bpay),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arpay(m_arpay),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rpay(m_rpay),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awpay(s_awpay),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wpay(s_wpay),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bpay(s_bpay),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arpay(s_arpay),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rpay(s_rpay));

    axi_nm_interconnect #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid(m_awvalid), .m_awready(f_awready), .m_awpay(m_awpay),
        .m_wvalid(m_wvalid), .m_wready(f_wready), .m_wpay(m_wpay),
        .m_bvalid(f_bvalid), .m_bready(m_bready), .m_bpay(f_bpay),
        .m_arvalid(m_arvalid), .m_arready(f_arready), .m_arpay(m_arpay),
        .m_rvalid(f_rvalid), .m_rready(m_rready), .m_rpay(f_rpay),
        .s_awvalid(f_awvalid), .s_awready(s_awready), .s_awpay(f_awpay),
        .s_wvalid(f_wvalid), .s_wready(s_wready), .s_wpay(f_wpay),
        .s_bvalid(s_bvalid), .s_bready(f_bready), .s_bpay(s_bpay),
        .s_arvalid(f_arvalid), .s_arready(s_arready), .s_arpay(f_arpay),
        .s_rvalid(s_rvalid), .s_rready(f_rready), .s_rpay(s_rpay));

    int checks = 0, failures = 0;
    int exp_rptr = 0;

    // Reference arbitration: the first requester scanning upward from ptr, wrapping at N.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [AP-1:0] rnd_ap();
        return AP'({$urandom(), $urandom()});
    endfunction

    task automatic idle_inputs();
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        m_awpay = '0; m_arpay = '0; m_wpay = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
        s_bpay = '0; s_rpay = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        m_arvalid = '1; m_awvalid = '1; m_wvalid = '1; m_rready = '1; m_bready = '1;
        s_rvalid = 1; s_bvalid = 1; s_wready = 1; s_arready = 1; s_awready = 1;
        #1;
        checks++; if (vr !== '0) begin failures++; $display("FAIL reset_rr: vr=%h want 0", vr); end
        checks++; if (f_vr !== '0) begin failures++; $display("FAIL reset_fp: vr=%h want 0", f_vr); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_rr_read();
        logic [AP-1:0] p0, p1;
        logic [DW-1:0] d0, d1;
        p0 = rnd_ap(); p1 = rnd_ap(); d0 = $urandom(); d1 = $urandom();
        @(negedge clk);
        m_arpay = {p1, p0}; m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1;
        #1;
        checks++; if (s_arvalid !== 1'b0) begin failures++; $display("FAIL rr_arb_cycle: s_arvalid=%b want 0", s_arvalid); end
        @(negedge clk); #1;
        checks++;
        if ({s_arvalid, m_arready, s_arpay} !== {1'b1, 2'b01, 1'b0, p0}) begin
            failures++; $display("FAIL rr_grant0: got %h want %h", {s_arvalid, m_arready, s_arpay}, {1'b1, 2'b01, 1'b0, p0});
        end
        @(negedge clk);
        m_arvalid = 2'b10; s_arready = 0; s_rvalid = 1;
        s_rpay = {1'b0, p0[AP-1 -: IW], d0, 2'b00, 1'b1};
        #1;
        checks++;
        if ({m_rvalid, s_rready, m_rpay} !== {2'b01, 1'b1, p0[AP-1 -: IW], d0, 2'b00, 1'b1}) begin
            failures++; $display("FAIL rr_rdata0: got %h want %h", {m_rvalid, s_rready, m_rpay}, {2'b01, 1'b1, p0[AP-1 -: IW], d0, 2'b00, 1'b1});
        end
        @(negedge clk);
        s_rvalid = 0; s_arready = 1;
        #1;
        checks++; if ({s_arvalid, m_rvalid} !== 3'b000) begin failures++; $display("FAIL rr_idle_gap: got %b want 000", {s_arvalid, m_rvalid}); end
        @(negedge clk); #1;
        checks++;
        if ({s_arvalid, m_arready, s_arpay} !== {1'b1, 2'b10, 1'b1, p1}) begin
            failures++; $display("FAIL rr_grant1: got %h want %h", {s_arvalid, m_arready, s_arpay}, {1'b1, 2'b10, 1'b1, p1});
        end
        @(negedge clk);
        m_arvalid = '0; s_arready = 0; s_rvalid = 1;
        s_rpay = {1'b1, p1[AP-1 -: IW], d1, 2'b01, 1'b1};
        #1;
        checks++;
        if ({m_rvalid, m_rpay} !== {2'b10, p1[AP-1 -: IW], d1, 2'b01, 1'b1}) begin
            failures++; $display("FAIL rr_rdata1: got %h want %h", {m_rvalid, m_rpay}, {2'b10, p1[AP-1 -: IW], d1, 2'b01, 1'b1});
        end
        @(negedge clk);
        idle_inputs();
        exp_rptr = 0;
    endtask

    task automatic test_arb_sequence();
        int got_rr[$], got_fp[$];
        int w, ptr;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        ptr = 0;
        m_arvalid = 2'b11; m_arpay = {rnd_ap(), rnd_ap()}; m_rready = 2'b11;
        s_arready = 1; s_rvalid = 1; s_rpay = {1'b0, IW'(0), DW'($urandom()), 2'b00, 1'b1};
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (s_arvalid && s_arready) got_rr.push_back(int'(s_arpay[MW+AP-1]));
            if (f_arvalid && s_arready) got_fp.push_back(int'(f_arpay[MW+AP-1]));
        end
        @(negedge clk);
        idle_inputs();
        checks++; if (got_rr.size() != 4) begin failures++; $display("FAIL arb_rr_count: got %0d want 4", got_rr.size()); end
        checks++; if (got_fp.size() != 4) begin failures++; $display("FAIL arb_fp_count: got %0d want 4", got_fp.size()); end
        for (int i = 0; i < 4 && i < got_rr.size(); i++) begin
            w = rr_pick(2'b11, ptr);
            ptr = (w + 1) % N;
            checks++; if (got_rr[i] != w) begin failures++; $display("FAIL arb_rr_seq%0d: got %0d want %0d", i, got_rr[i], w); end
        end
        for (int i = 0; i < 4 && i < got_fp.size(); i++) begin
            checks++; if (got_fp[i] != 0) begin failures++; $display("FAIL arb_fp_seq%0d: got %0d want 0", i, got_fp[i]); end
        end
        exp_rptr = ptr;
    endtask

    task automatic test_write_burst();
        logic [AP-1:0] ap;
        logic [WP-1:0] beats[0:4];
        int got, cyc;
        ap = rnd_ap(); ap[12:5] = 8'd3;
        for (int i = 0; i < 4; i++) beats[i] = {DW'($urandom()), SW'($urandom()), 1'(i == 3)};
        beats[4] = '0;
        @(negedge clk);
        m_awpay = {ap, AP'(0)}; m_awvalid = 2'b10; s_awready = 1;
        #1;
        checks++; if (s_awvalid !== 1'b0) begin failures++; $display("FAIL wr_arb_cycle: s_awvalid=%b want 0", s_awvalid); end
        @(negedge clk); #1;
        checks++;
        if ({s_awvalid, m_awready, s_awpay} !== {1'b1, 2'b10, 1'b1, ap}) begin
            failures++; $display("FAIL wr_aw: got %h want %h", {s_awvalid, m_awready, s_awpay}, {1'b1, 2'b10, 1'b1, ap});
        end
        got = 0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            @(negedge clk);
            m_awvalid = '0; s_awready = 0;
            s_wready = (cyc % 2 == 0);
            m_wvalid = 2'b10; m_wpay = {beats[got], WP'(0)};
            #1;
            checks++;
            if ({s_wvalid, m_wready} !== {1'b1, s_wready, 1'b0}) begin
                failures++; $display("FAIL wr_wready c%0d: got %b want %b", cyc, {s_wvalid, m_wready}, {1'b1, s_wready, 1'b0});
            end
            if (s_wvalid && s_wready) begin
                checks++; if (s_wpay !== beats[got]) begin failures++; $display("FAIL wr_beat%0d: got %h want %h", got, s_wpay, beats[got]); end
                got++;
            end
            cyc++;
        end
        checks++; if (got != 4) begin failures++; $display("FAIL wr_beats_count: got %0d want 4", got); end
        @(negedge clk);
        m_wvalid = '0; s_wready = 0; s_bvalid = 1; s_bpay = {1'b1, 4'h5, 2'b10}; m_bready = 2'b10;
        #1;
        checks++;
        if ({m_bvalid, s_bready, m_bpay} !== {2'b10, 1'b1, 4'h5, 2'b10}) begin
            failures++; $display("FAIL wr_bresp: got %h want %h", {m_bvalid, s_bready, m_bpay}, {2'b10, 1'b1, 4'h5, 2'b10});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_w_before_aw();
        logic [WP-1:0] wb;
        logic [IW-1:0] bid;
        wb = {DW'($urandom()), SW'($urandom()), 1'b1};
        bid = IW'($urandom());
        @(negedge clk);
        m_wvalid = 2'b01; m_wpay = {WP'(0), wb}; s_wready = 1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if ({m_wready, s_wvalid} !== 3'b000) begin failures++; $display("FAIL early_w%0d: got %b want 000", i, {m_wready, s_wvalid}); end
        end
        @(negedge clk);
        m_awvalid = 2'b01; m_awpay = {AP'(0), rnd_ap()}; s_awready = 1;
        #1;
        checks++; if (m_wready !== 2'b00) begin failures++; $display("FAIL early_w_arb: m_wready=%b want 00", m_wready); end
        @(negedge clk); #1;
        checks++; if ({s_awvalid, m_wready} !== 3'b100) begin failures++; $display("FAIL early_w_addr: got %b want 100", {s_awvalid, m_wready}); end
        @(negedge clk);
        m_awvalid = '0; s_awready = 0;
        #1;
        checks++;
        if ({m_wready, s_wvalid, s_wpay} !== {2'b01, 1'b1, wb}) begin
            failures++; $display("FAIL early_w_data: got %h want %h", {m_wready, s_wvalid, s_wpay}, {2'b01, 1'b1, wb});
        end
        @(negedge clk);
        m_wvalid = '0; s_wready = 0; s_bvalid = 1; s_bpay = {1'b0, bid, 2'b01}; m_bready = 2'b01;
        #1;
        checks++; if ({m_bvalid, m_bpay} !== {2'b01, bid, 2'b01}) begin failures++; $display("FAIL early_w_b: got %h want %h", {m_bvalid, m_bpay}, {2'b01, bid, 2'b01}); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_concurrent();
        logic [AP-1:0] rap, wap;
        logic [DW-1:0] rdata[0:4];
        logic [WP-1:0] wbeats[0:2];
        int rbeat, wbeat, cyc;
        bit bdone;
        rap = rnd_ap(); wap = rnd_ap();
        for (int i = 0; i < 5; i++) rdata[i] = $urandom();
        for (int i = 0; i < 2; i++) wbeats[i] = {DW'($urandom()), SW'($urandom()), 1'(i == 1)};
        wbeats[2] = '0;
        @(negedge clk);
        m_arvalid = 2'b01; m_awvalid = 2'b10; m_arpay = {AP'(0), rap}; m_awpay = {wap, AP'(0)};
        m_wvalid = 2'b10; m_wpay = {wbeats[0], WP'(0)};
        s_arready = 1; s_awready = 1; m_rready = 2'b01; m_bready = 2'b10;
        @(negedge clk); #1;
        checks++;
        if ({s_arvalid, s_awvalid, s_arpay, s_awpay} !== {2'b11, 1'b0, rap, 1'b1, wap}) begin
            failures++; $display("FAIL conc_addr: got %h want %h", {s_arvalid, s_awvalid, s_arpay, s_awpay}, {2'b11, 1'b0, rap, 1'b1, wap});
        end
        rbeat = 0; wbeat = 0; bdone = 0; cyc = 0;
        while (!(rbeat == 4 && bdone) && cyc < 60) begin
            @(negedge clk);
            m_arvalid = '0; m_awvalid = '0; s_arready = 0; s_awready = 0;
            s_rvalid = (rbeat < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_rpay = {1'b0, rap[AP-1 -: IW], rdata[rbeat], 2'b00, 1'(rbeat == 3)};
            m_wvalid = {1'(wbeat < 2), 1'b0};
            m_wpay = {wbeats[wbeat], WP'(0)};
            s_wready = 1'($urandom_range(0, 1));
            s_bvalid = (wbeat == 2 && !bdone);
            s_bpay = {1'b1, wap[AP-1 -: IW], 2'b00};
            #1;
            if (rbeat < 4) begin
                checks++; if (m_rvalid !== {1'b0, s_rvalid}) begin failures++; $display("FAIL conc_rroute c%0d: got %b want %b", cyc, m_rvalid, {1'b0, s_rvalid}); end
            end
            if (m_rvalid[0] && m_rready[0]) begin
                checks++;
                if (m_rpay !== {rap[AP-1 -: IW], rdata[rbeat], 2'b00, 1'(rbeat == 3)}) begin
                    failures++; $display("FAIL conc_rbeat%0d: got %h want %h", rbeat, m_rpay, {rap[AP-1 -: IW], rdata[rbeat], 2'b00, 1'(rbeat == 3)});
                end
                rbeat++;
            end
            if (s_wvalid && s_wready) begin
                checks++; if (s_wpay !== wbeats[wbeat]) begin failures++; $display("FAIL conc_wbeat%0d: got %h want %h", wbeat, s_wpay, wbeats[wbeat]); end
                wbeat++;
            end
            if (m_bvalid[1] && m_bready[1]) begin
                checks++; if (m_bpay !== {wap[AP-1 -: IW], 2'b00}) begin failures++; $display("FAIL conc_b: got %h want %h", m_bpay, {wap[AP-1 -: IW], 2'b00}); end
                bdone = 1;
            end
            cyc++;
        end
        checks++; if (!(rbeat == 4 && bdone)) begin failures++; $display("FAIL conc_done: rbeats=%0d bdone=%0d want 4/1", rbeat, bdone); end
        @(negedge clk);
        idle_inputs();
        exp_rptr = 1;
    endtask

    task automatic test_reset_midburst();
        logic [AP-1:0] p1;
        @(negedge clk);
        m_arvalid = 2'b01; m_arpay = {AP'(0), rnd_ap()}; s_arready = 1; m_rready = 2'b01;
        @(negedge clk);
        @(negedge clk);
        m_arvalid = '0; s_arready = 0; s_rvalid = 1; s_rpay = {1'b0, IW'(0), DW'($urandom()), 2'b00, 1'b0};
        @(negedge clk);
        s_rpay = {1'b0, IW'(0), DW'($urandom()), 2'b00, 1'b0};
        #1;
        checks++; if (m_rvalid !== 2'b01) begin failures++; $display("FAIL mid_beat2: m_rvalid=%b want 01", m_rvalid); end
        #1 rst_n = 0;
        #1;
        checks++; if (vr !== '0) begin failures++; $display("FAIL mid_rst_rr: vr=%h want 0", vr); end
        checks++; if (f_vr !== '0) begin failures++; $display("FAIL mid_rst_fp: vr=%h want 0", f_vr); end
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        p1 = rnd_ap();
        m_arvalid = 2'b10; m_arpay = {p1, AP'(0)}; s_arready = 1;
        #1;
        checks++; if (s_arvalid !== 1'b0) begin failures++; $display("FAIL mid_arb_cycle: s_arvalid=%b want 0", s_arvalid); end
        @(negedge clk); #1;
        checks++;
        if ({s_arvalid, m_arready, s_arpay} !== {1'b1, 2'b10, 1'b1, p1}) begin
            failures++; $display("FAIL mid_m1_grant: got %h want %h", {s_arvalid, m_arready, s_arpay}, {1'b1, 2'b10, 1'b1, p1});
        end
        @(negedge clk);
        m_arvalid = '0; s_arready = 0; s_rvalid = 1; m_rready = 2'b10;
        s_rpay = {1'b1, p1[AP-1 -: IW], DW'($urandom()), 2'b00, 1'b1};
        @(negedge clk);
        idle_inputs();
        exp_rptr = 0;
    endtask

    task automatic test_reset_ptr();
        // Leave the pointer at 1, then check that reset clears it.
        @(negedge clk);
        m_arvalid = 2'b01; m_arpay = {AP'(0), rnd_ap()}; s_arready = 1; m_rready = 2'b01;
        s_rvalid = 1; s_rpay = {1'b0, IW'(0), DW'($urandom()), 2'b00, 1'b1};
        repeat (3) @(negedge clk);
        idle_inputs();
        exp_rptr = (rr_pick(2'b01, exp_rptr) + 1) % N;
        #2 rst_n = 0;
        exp_rptr = 0;
        @(negedge clk);
        rst_n = 1;
        m_arvalid = 2'b11; m_arpay = {rnd_ap(), rnd_ap()}; s_arready = 1;
        @(negedge clk); #1;
        checks++;
        if ({s_arvalid, s_arpay[MW+AP-1]} !== {1'b1, 1'(rr_pick(2'b11, exp_rptr))}) begin
            failures++; $display("FAIL rptr_after_reset: got %b want %b", {s_arvalid, s_arpay[MW+AP-1]}, {1'b1, 1'(rr_pick(2'b11, exp_rptr))});
        end
        @(negedge clk);
        m_arvalid = '0; s_arready = 0; s_rvalid = 1; m_rready = 2'b11;
        s_rpay = {1'b0, IW'(0), DW'($urandom()), 2'b00, 1'b1};
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rr_read();
        test_arb_sequence();
        test_write_burst();
        test_w_before_aw();
        test_concurrent();
        test_reset_midburst();
        test_reset_ptr();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
